// File: rtl/fpu_pkg.sv
// Shared FPU widths, biases, unpacker state encoding and class-flag bundle.
package fpu_pkg;

   localparam int unsigned EXP_W_DB  = 11;
   localparam int unsigned FRAC_W_DB = 52;
   localparam int unsigned EXP_W_SP  = 8;
   localparam int unsigned FRAC_W_SP = 23;
   localparam int unsigned E_W       = 13;
   localparam int unsigned F_W       = 53;
   localparam int unsigned LZ_W      = 6;

   localparam int BIAS_DB = 1023;
   localparam int BIAS_SP = 127;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      DONE
   } state_t;

   typedef struct packed {
      logic ZERO;
      logic INF;
      logic NAN;
      logic SNAN;
      logic DENORM;
   } fp_class_t;

endpackage

// File: rtl/fp_unpack_seq_classify.sv
// Combinational field extraction and IEEE class decode for double or single operands.
module fp_classify
   import fpu_pkg::*;
(
   input  logic [63:0]          fp_in,
   input  logic                 db,
   output logic                 s,
   output logic [EXP_W_DB-1:0]  exp_f,
   output logic [FRAC_W_DB-1:0] frac,
   output logic                 exp_zero,
   output fp_class_t            cls
);

   logic exp_ones;
   logic frac_nz;

   // Select the field layout; single fractions are left-aligned into 52 bits.
   always_comb begin
      s        = fp_in[63];
      exp_f    = '0;
      frac     = '0;
      exp_ones = 1'b0;
      if (db) begin
         exp_f    = fp_in[62:52];
         frac     = fp_in[51:0];
         exp_ones = &fp_in[62:52];
      end else begin
         exp_f    = {3'b000, fp_in[62:55]};
         frac     = {fp_in[54:32], 29'b0};
         exp_ones = &fp_in[62:55];
      end
   end

   // Class flags derived from the extracted fields.
   always_comb begin
      exp_zero   = (exp_f == '0);
      frac_nz    = |frac;
      cls.ZERO   = exp_zero && !frac_nz;
      cls.DENORM = exp_zero && frac_nz;
      cls.INF    = exp_ones && !frac_nz;
      cls.NAN    = exp_ones && frac_nz;
      cls.SNAN   = exp_ones && frac_nz && !frac[FRAC_W_DB-1];
   end

endmodule

// File: rtl/fp_unpack_seq.sv
// Operand unpacker: classifies a packed IEEE word, optionally normalises
// denormals over several cycles, and hands the result over valid/ready.
module fp_unpack_seq
   import fpu_pkg::*;
#(
   parameter int unsigned STEP = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       fp_in,
   input  logic              db,
   input  logic              normen,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              s,
   output logic [E_W-1:0]    e,
   output logic [F_W-1:0]    f,
   output logic [LZ_W-1:0]   lz,
   output logic [F_W-1:0]    nan,
   output logic              ZERO,
   output logic              INF,
   output logic              NAN,
   output logic              SNAN,
   output logic              DENORM
);

   state_t                 state, state_nx;
   logic                   s_nx;
   logic [E_W-1:0]         e_nx;
   logic [F_W-1:0]         f_nx;
   logic [LZ_W-1:0]        lz_nx;
   logic [F_W-1:0]         nan_nx;
   fp_class_t              cls_q, cls_nx;

   logic                   c_s;
   logic [EXP_W_DB-1:0]    c_exp;
   logic [FRAC_W_DB-1:0]   c_frac;
   logic                   c_exp_zero;
   fp_class_t              c_cls;
   logic [E_W-1:0]         bias;
   logic [E_W-1:0]         c_e;

   logic                   coarse;
   logic [F_W-1:0]         f_norm;
   logic [LZ_W-1:0]        sh;

   fp_classify u_classify (
      .fp_in    (fp_in),
      .db       (db),
      .s        (c_s),
      .exp_f    (c_exp),
      .frac     (c_frac),
      .exp_zero (c_exp_zero),
      .cls      (c_cls)
   );

   // Unbiased exponent of the incoming operand; denormals use the minimum normal exponent.
   always_comb begin
      bias = db ? E_W'(BIAS_DB) : E_W'(BIAS_SP);
      c_e  = c_exp_zero ? (E_W'(1) - bias) : ({2'b00, c_exp} - bias);
   end

   // One normalisation step: coarse STEP shift while the top STEP bits are clear, else single-bit.
   always_comb begin
      coarse = (f[F_W-1 -: STEP] == '0);
      f_norm = coarse ? (f << STEP) : (f << 1);
      sh     = coarse ? LZ_W'(STEP) : LZ_W'(1);
   end

   // Next-state and next-data logic for the IDLE / NORM / DONE sequence.
   always_comb begin
      state_nx = state;
      s_nx     = s;
      e_nx     = e;
      f_nx     = f;
      lz_nx    = lz;
      nan_nx   = nan;
      cls_nx   = cls_q;
      case (state)
         IDLE: begin
            if (in_valid) begin
               s_nx     = c_s;
               e_nx     = c_e;
               f_nx     = {!c_exp_zero, c_frac};
               lz_nx    = '0;
               nan_nx   = {c_s, 1'b1, c_frac[FRAC_W_DB-2:0]};
               cls_nx   = c_cls;
               state_nx = (c_cls.DENORM && normen) ? NORM : DONE;
            end
         end
         NORM: begin
            f_nx  = f_norm;
            e_nx  = e - {{(E_W-LZ_W){1'b0}}, sh};
            lz_nx = lz + sh;
            if (f_norm[F_W-1]) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and result registers; reset discards any operand in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         s     <= 1'b0;
         e     <= '0;
         f     <= '0;
         lz    <= '0;
         nan   <= '0;
         cls_q <= '0;
      end else begin
         state <= state_nx;
         s     <= s_nx;
         e     <= e_nx;
         f     <= f_nx;
         lz    <= lz_nx;
         nan   <= nan_nx;
         cls_q <= cls_nx;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign ZERO      = cls_q.ZERO;
   assign INF       = cls_q.INF;
   assign NAN       = cls_q.NAN;
   assign SNAN      = cls_q.SNAN;
   assign DENORM    = cls_q.DENORM;

endmodule
